branch_resolver: RTL

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// Prediction queue checked in order against execute outcomes; a mispredict flushes the queue and redirects fetch.
// Optional BR_STATS_EN adds saturating resolved-branch and mispredict counters.
module branch_resolver #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pq_push,
  input  logic [AW-1:0] pq_pc,
  input  logic          pq_hit,
  input  logic          pq_taken,
  input  logic [AW-1:0] pq_paddr,
  output logic          pq_full,
  input  logic          res_valid,
  input  logic          res_taken,
  input  logic [AW-1:0] res_target,
  output logic          res_ready,
  output logic          mispred,
  output logic [AW-1:0] t_addr,
  output logic [AW-1:0] tp_addr,
  output logic          redirect,
  output logic [AW-1:0] redirect_pc,
  output logic [31:0]   br_cnt,
  output logic [31:0]   mp_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] pc_mem    [DEPTH];
  logic          hit_mem   [DEPTH];
  logic          taken_mem [DEPTH];
  logic [AW-1:0] paddr_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          ready_q, ready_d;
  logic          mispred_q;
  logic [AW-1:0] t_addr_q, t_addr_d;
  logic [AW-1:0] tp_addr_q, tp_addr_d;
  logic [AW-1:0] rpc_q, rpc_d;

  logic          res_acc;
  logic          push_acc;
  logic          head_ptaken;
  logic          mp;

  always_comb begin
    head_ptaken = hit_mem[rd_ptr_q] & taken_mem[rd_ptr_q];
    res_acc     = res_valid & ready_q;
    mp          = res_acc & ((head_ptaken != res_taken) |
                  (head_ptaken & res_taken & (paddr_mem[rd_ptr_q] != res_target)));
    // A full queue still takes a push when the head retires in the same cycle.
    push_acc    = pq_push & ~mispred_q & (~full_q | res_acc);

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    t_addr_d  = t_addr_q;
    tp_addr_d = tp_addr_q;
    rpc_d     = rpc_q;

    if (mp) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      t_addr_d  = pc_mem[rd_ptr_q];
      tp_addr_d = res_target;
      rpc_d     = res_taken ? res_target : pc_mem[rd_ptr_q] + AW'(4);
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (res_acc)  rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push_acc) - CW'(res_acc);
    end

    full_d  = (cnt_d == CW'(DEPTH));
    ready_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push_acc && !mp) begin
      pc_mem[wr_ptr_q]    <= pq_pc;
      hit_mem[wr_ptr_q]   <= pq_hit;
      taken_mem[wr_ptr_q] <= pq_taken;
      paddr_mem[wr_ptr_q] <= pq_paddr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      ready_q   <= 1'b0;
      mispred_q <= 1'b0;
      t_addr_q  <= '0;
      tp_addr_q <= '0;
      rpc_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      ready_q   <= ready_d;
      mispred_q <= mp;
      t_addr_q  <= t_addr_d;
      tp_addr_q <= tp_addr_d;
      rpc_q     <= rpc_d;
    end
  end

  assign pq_full     = full_q;
  assign res_ready   = ready_q;
  assign mispred     = mispred_q;
  assign redirect    = mispred_q;
  assign t_addr      = t_addr_q;
  assign tp_addr     = tp_addr_q;
  assign redirect_pc = rpc_q;

`ifdef BR_STATS_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (res_acc && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + 32'd1;
      if (mp && (mp_cnt_q != '1))      mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign br_cnt = br_cnt_q;
  assign mp_cnt = mp_cnt_q;
`else
  assign br_cnt = '0;
  assign mp_cnt = '0;
`endif

endmodule
